ram_banked_clr: RTL and testbench
=================================

// Module: ram_banked_clr
// PURPOSE
//  Parametrised banked single-port RAM; successor to the fixed 64x16 RAM.
//  Width, depth and bank count are parameters. Upper address bits select a bank, lower bits select the word.
//  Read data is registered. A built-in clear sequencer zeroes every word after reset or on request, and reports busy.
//  Sits under the register file and scratch-memory blocks as their storage primitive.
// PARAMETERS
//  WIDTH       16  data word width in bits
//  ADDR_W      6   address width; DEPTH = 2**ADDR_W words
//  BANK_W      2   bank-select width; NBANK = 2**BANK_W; BANK_W < ADDR_W
// PORTS
//  clk      in   1        single clock; all state updates on posedge
//  rst      in   1        synchronous reset, active-high
//  en       in   1        access request; sampled only when busy=0
//  rw       in   1        1 = write, 0 = read (qualified by en)
//  address  in   ADDR_W   word address; [ADDR_W-1 -: BANK_W] = bank, rest = word
//  in       in   WIDTH    write data
//  clr      in   1        start-clear pulse; sampled only when busy=0
//  out      out  WIDTH    registered read data
//  valid    out  1        1-cycle pulse: out holds data for the read accepted last cycle
//  busy     out  1        clear sequence in progress; requests ignored
// BEHAVIOUR
//  Reset: one clock, synchronous active-high reset (rst), both fixed.
//   - While rst=1: state=CLEAR, clear counter=0, out=0, valid=0, busy=1.
//   - Memory contents are not reset directly; the clear sweep zeroes them.
//  States: CLEAR, IDLE.
//   - CLEAR: each cycle writes 0 to word[cnt] and increments cnt.
//     When cnt = DEPTH-1 is written, go to IDLE and drop busy next cycle.
//     Sweep takes exactly DEPTH cycles after rst falls.
//   - IDLE: busy=0. On clr=1, enter CLEAR with cnt=0 (clr has priority over en in the same cycle).
//  Accesses in IDLE:
//   - Write (en=1, rw=1): word[address] <= in at the edge; valid=0; out unchanged.
//   - Read (en=1, rw=0): out <= word[address] at the edge; valid=1 for that one cycle. Latency 1.
//   - en=0: out holds its last value; valid=0.
//  Busy behaviour: en and clr are ignored while busy=1. No queuing, no error flag.
//   - A request made in the cycle busy falls is accepted.
//  Read-after-write to the same address on consecutive cycles returns the new data (no hazard).
//  Bank decode:
//   - Only the selected bank is enabled (one-hot demux of en).
//   - out is the selected bank's read data, chosen by a bank select registered with the read, so unselected banks never corrupt out.
//  Mid-operation events:
//   - rst during CLEAR restarts the sweep at 0.
//   - rst during IDLE discards any access in that cycle and starts a full clear.
//  Address wraps naturally; every ADDR_W-bit value is legal.
// STRUCTURE
//  Shared package ram_pkg: state encoding localparams ST_IDLE=1'b0, ST_CLEAR=1'b1; RW_READ/RW_WRITE constants.
//  Sub-module ram_bank (WIDTH, ADDR_W-BANK_W): single-port bank with synchronous write and registered read.
//   - Instantiate NBANK copies in a generate loop.
//  Top level holds: the en demux, the clear FSM and counter (ADDR_W bits), the registered bank select, the output mux, and valid.
//  During CLEAR, the FSM drives every bank's write port with data 0 and word index cnt[ADDR_W-BANK_W-1:0], enabling only bank cnt[ADDR_W-1 -: BANK_W].
// TESTING (defaults: WIDTH=16, DEPTH=64, NBANK=4)
//  1. Clear after reset:
//     - Stimulus: rst 1 cycle.
//     - Required: busy=1 for exactly 64 cycles after rst falls; then reads of addr 0, 17, 63 return 0x0000 with valid pulse.
//  2. Bank isolation:
//     - Stimulus: write 0xA5A5@0x05, 0x5A5A@0x15, 0xFFFF@0x25, 0x1234@0x35.
//     - Required: read back each value 1 cycle after its request; no cross-bank corruption.
//  3. Back-to-back:
//     - Stimulus: write 0xBEEF@0x3F, read 0x3F on the next cycle.
//     - Required: out=0xBEEF, valid=1 on the following cycle. Idle cycle after that: out stays 0xBEEF, valid=0.
//  4. Busy gating:
//     - Stimulus: preload 0x1111@0x00, then clr=1 together with a write of 0x2222@0x00; also issue reads during the sweep.
//     - Required: the write is dropped, in-sweep reads give valid=0, and a read after busy falls returns 0x0000.
//  5. Reset mid-clear:
//     - Stimulus: assert rst at cycle 30 of the sweep.
//     - Required: busy stays 1, and the sweep completes 64 cycles after rst falls.
//  6. Parameter sweep:
//     - Stimulus: WIDTH=8, ADDR_W=4, BANK_W=1; random write/read traffic.
//     - Required: a scoreboard model matches every valid read; the clear sweep takes 16 cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state encoding and access-direction constants for the banked RAM
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - single-port RAM bank with synchronous write and registered read
module ram_bank
  import ram_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && we == RW_READ) rdata_d = mem_q[addr];
  end

  // Storage is deliberately not reset; the top-level clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (en && we == RW_WRITE) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_banked_clr.sv
// rtl/ram_banked_clr.sv - banked single-port RAM with registered read and a built-in clear sweep
module ram_banked_clr
  import ram_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6,
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rw,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  input  logic              clr,
  output logic [WIDTH-1:0]  out,
  output logic              valid,
  output logic              busy
);

  localparam int WORD_W = ADDR_W - BANK_W;
  localparam int NBANK  = 2**BANK_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [BANK_W-1:0] bank_sel_q, bank_sel_d;

  logic [NBANK-1:0]  bank_en;
  logic              bank_we;
  logic [WORD_W-1:0] bank_addr;
  logic [WIDTH-1:0]  bank_wdata;
  logic [WIDTH-1:0]  bank_rdata [NBANK];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    bank_sel_d = bank_sel_q;
    bank_en    = '0;
    bank_we    = RW_READ;
    bank_addr  = address[WORD_W-1:0];
    bank_wdata = in;
    // Any access coinciding with reset is discarded.
    if (!rst) begin
      case (state_q)
        ST_CLEAR: begin
          bank_en[cnt_q[ADDR_W-1 -: BANK_W]] = 1'b1;
          bank_we    = RW_WRITE;
          bank_addr  = cnt_q[WORD_W-1:0];
          bank_wdata = '0;
          cnt_d      = cnt_q + ADDR_W'(1);
          if (cnt_q == '1) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (clr) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end else if (en) begin
            bank_en[address[ADDR_W-1 -: BANK_W]] = 1'b1;
            bank_we = rw;
            if (rw == RW_READ) begin
              valid_d    = 1'b1;
              bank_sel_d = address[ADDR_W-1 -: BANK_W];
            end
          end
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      bank_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      bank_sel_q <= bank_sel_d;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    ram_bank #(
      .WIDTH(WIDTH),
      .AW   (WORD_W)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .en   (bank_en[b]),
      .we   (bank_we),
      .addr (bank_addr),
      .wdata(bank_wdata),
      .rdata(bank_rdata[b])
    );
  end

  // Bank select is registered with the read so other banks' traffic cannot disturb out.
  assign out   = bank_rdata[bank_sel_q];
  assign valid = valid_q;
  assign busy  = rst || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_banked_clr.sv
// tb/tb_ram_banked_clr.sv - self-checking bench for ram_banked_clr (default and small parameter sets)
module tb_ram_banked_clr;

  logic        clk;
  logic        rst, en, rw, clr;
  logic [5:0]  address;
  logic [15:0] din, dout;
  logic        valid, busy;

  logic        p_rst, p_en, p_rw, p_clr;
  logic [3:0]  p_addr;
  logic [7:0]  p_din, p_dout;
  logic        p_valid, p_busy;

  int checks = 0;
  int failures = 0;

  logic [15:0] ref_mem [64];
  logic [15:0] ref_out;
  logic [7:0]  p_mem [16];
  logic [7:0]  p_ref_out;

  ram_banked_clr dut (
    .clk(clk), .rst(rst), .en(en), .rw(rw), .address(address), .in(din),
    .clr(clr), .out(dout), .valid(valid), .busy(busy)
  );

  ram_banked_clr #(.WIDTH(8), .ADDR_W(4), .BANK_W(1)) dut_p (
    .clk(clk), .rst(p_rst), .en(p_en), .rw(p_rw), .address(p_addr), .in(p_din),
    .clr(p_clr), .out(p_dout), .valid(p_valid), .busy(p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic [5:0] a, input logic [15:0] d);
    en = e; rw = w; address = a; din = d;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [5:0] addrs [3];
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (dout !== 16'h0) begin failures++; $display("FAIL reset_out got=%h exp=0000", dout); end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin tick(); n++; end
    checks++; if (n != 64) begin failures++; $display("FAIL clear_len got=%0d exp=64", n); end
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0;
    addrs[0] = 6'd0; addrs[1] = 6'd17; addrs[2] = 6'd63;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, addrs[i], 16'h0);
      checks++; if (valid !== 1'b1 || dout !== 16'h0)
        begin failures++; $display("FAIL clear_read a=%0d got=%b/%h exp=1/0000", addrs[i], valid, dout); end
    end
    ref_out = 16'h0;
  endtask

  task automatic test_bank_isolation();
    logic [5:0]  a [4];
    logic [15:0] d [4];
    a[0] = 6'h05; a[1] = 6'h15; a[2] = 6'h25; a[3] = 6'h35;
    d[0] = 16'hA5A5; d[1] = 16'h5A5A; d[2] = 16'hFFFF; d[3] = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, a[i], d[i]);
      ref_mem[a[i]] = d[i];
      checks++; if (valid !== 1'b0 || dout !== ref_out)
        begin failures++; $display("FAIL iso_write a=%h got=%b/%h exp=0/%h", a[i], valid, dout, ref_out); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, a[i], 16'h0);
      ref_out = ref_mem[a[i]];
      checks++; if (valid !== 1'b1 || dout !== d[i])
        begin failures++; $display("FAIL iso_read a=%h got=%b/%h exp=1/%h", a[i], valid, dout, d[i]); end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 6'h3F, 16'hBEEF);
    ref_mem[63] = 16'hBEEF;
    drive(1'b1, 1'b0, 6'h3F, 16'h0);
    checks++; if (valid !== 1'b1 || dout !== 16'hBEEF)
      begin failures++; $display("FAIL b2b_read got=%b/%h exp=1/beef", valid, dout); end
    drive(1'b0, 1'b0, 6'h00, 16'h0);
    checks++; if (valid !== 1'b0 || dout !== 16'hBEEF)
      begin failures++; $display("FAIL b2b_hold got=%b/%h exp=0/beef", valid, dout); end
    ref_out = 16'hBEEF;
  endtask

  task automatic test_busy_gating();
    int n;
    int bad;
    drive(1'b1, 1'b1, 6'h00, 16'h1111);
    clr = 1'b1;
    drive(1'b1, 1'b1, 6'h00, 16'h2222);
    clr = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gate_busy got=%b exp=1", busy); end
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 200) begin
      drive(1'b1, 1'b0, 6'($urandom), 16'h0);
      if (valid !== 1'b0) bad++;
      n++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL gate_valid got=%0d exp=0 valid pulses in sweep", bad); end
    checks++; if (n != 64) begin failures++; $display("FAIL gate_len got=%0d exp=64", n); end
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0;
    drive(1'b1, 1'b0, 6'h00, 16'h0);
    checks++; if (valid !== 1'b1 || dout !== 16'h0)
      begin failures++; $display("FAIL gate_read got=%b/%h exp=1/0000", valid, dout); end
    ref_out = 16'h0;
  endtask

  task automatic test_reset_mid_clear();
    int n;
    drive(1'b1, 1'b1, 6'h3E, 16'h7777);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%b exp=1", busy); end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin tick(); n++; end
    checks++; if (n != 64) begin failures++; $display("FAIL midrst_len got=%0d exp=64", n); end
    drive(1'b1, 1'b0, 6'h3E, 16'h0);
    checks++; if (valid !== 1'b1 || dout !== 16'h0)
      begin failures++; $display("FAIL midrst_read got=%b/%h exp=1/0000", valid, dout); end
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0;
    ref_out = 16'h0;
  endtask

  task automatic test_random();
    int bad;
    logic e, w;
    logic [5:0] a;
    logic [15:0] d;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      e = 1'($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      a = 6'($urandom);
      d = 16'($urandom);
      drive(e, w, a, d);
      if (e && !w) begin
        ref_out = ref_mem[a];
        if (valid !== 1'b1 || dout !== ref_out) begin
          bad++;
          if (bad < 5) $display("FAIL rand_read a=%h got=%b/%h exp=1/%h", a, valid, dout, ref_out);
        end
      end else if (valid !== 1'b0 || dout !== ref_out) begin
        bad++;
        if (bad < 5) $display("FAIL rand_idle got=%b/%h exp=0/%h", valid, dout, ref_out);
      end
      if (e && w) ref_mem[a] = d;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_total got=%0d exp=0 mismatched cycles", bad); end
  endtask

  task automatic test_param_sweep();
    int n;
    int bad;
    logic e, w;
    logic [3:0] a;
    logic [7:0] d;
    p_rst = 1'b1;
    tick();
    checks++; if (p_busy !== 1'b1 || p_valid !== 1'b0 || p_dout !== 8'h0)
      begin failures++; $display("FAIL p_reset got=%b/%b/%h exp=1/0/00", p_busy, p_valid, p_dout); end
    p_rst = 1'b0;
    n = 0;
    while (p_busy === 1'b1 && n < 100) begin tick(); n++; end
    checks++; if (n != 16) begin failures++; $display("FAIL p_clear_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) p_mem[i] = 8'h0;
    p_ref_out = 8'h0;
    bad = 0;
    for (int i = 0; i < 250; i++) begin
      e = 1'($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom);
      d = 8'($urandom);
      p_en = e; p_rw = w; p_addr = a; p_din = d;
      tick();
      p_en = 1'b0;
      if (e && !w) begin
        p_ref_out = p_mem[a];
        if (p_valid !== 1'b1 || p_dout !== p_ref_out) begin
          bad++;
          if (bad < 5) $display("FAIL p_read a=%h got=%b/%h exp=1/%h", a, p_valid, p_dout, p_ref_out);
        end
      end else if (p_valid !== 1'b0 || p_dout !== p_ref_out) begin
        bad++;
        if (bad < 5) $display("FAIL p_idle got=%b/%h exp=0/%h", p_valid, p_dout, p_ref_out);
      end
      if (e && w) p_mem[a] = d;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL p_total got=%0d exp=0 mismatched cycles", bad); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rw = 1'b0; clr = 1'b0; address = '0; din = '0;
    p_rst = 1'b1; p_en = 1'b0; p_rw = 1'b0; p_clr = 1'b0; p_addr = '0; p_din = '0;
    ref_out = '0; p_ref_out = '0;
    test_reset();
    test_bank_isolation();
    test_back_to_back();
    test_busy_gating();
    test_reset_mid_clear();
    test_random();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
